// File: rtl/mod_exp_if.sv
// Start/busy/valid handshake and operand/result bus of the modular exponentiator.
interface mod_exp_if #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
);
  logic                 ready_in;
  logic [WIDTH-1:0]     base_in;
  logic [EXP_WIDTH-1:0] exponent_in;
  logic [WIDTH-1:0]     modulus_in;
  logic [WIDTH-1:0]     result_out;
  logic                 busy_out;
  logic                 valid_out;

  modport master (
    output ready_in, base_in, exponent_in, modulus_in,
    input  result_out, busy_out, valid_out
  );

  modport slave (
    input  ready_in, base_in, exponent_in, modulus_in,
    output result_out, busy_out, valid_out
  );
endinterface

// File: rtl/mod_exp.sv
// base^exponent mod modulus, left-to-right square-and-multiply; MOD_EXP_EARLY_EXIT_EN skips MUL for 0 bits.
// Latency (2*EXP_WIDTH+1)*(2*WIDTH+1)+1 cycles (1 if modulus==0); ready_in ignored unless IDLE.
module mod_exp #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic     clk_in,
  input  logic     rst_n_in,
  mod_exp_if.slave bus
);
  localparam int CW = $clog2(2*WIDTH+1);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2*WIDTH);
  localparam logic [IW-1:0] IDX_TOP  = IW'(EXP_WIDTH-1);

  typedef enum logic [2:0] {IDLE, REDUCE_BASE, SQR, MUL, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   p;
  logic [WIDTH-1:0]     r;
  logic [WIDTH-1:0]     acc, b, m, result;
  logic [EXP_WIDTH-1:0] e;
  logic [IW-1:0]        idx;

  logic                 in_op, op_last, ebit;
  logic [WIDTH:0]       r_sh, r_nxt;
  logic [WIDTH-1:0]     op_res, mul_b, acc_upd;
  logic [2*WIDTH-1:0]   prod;

  assign in_op   = (state == REDUCE_BASE) || (state == SQR) || (state == MUL);
  assign op_last = in_op && (cnt == CNT_LAST);
  assign ebit    = e[idx];

  // The stored remainder is always < m, so only the shifted value needs the extra bit.
  assign r_sh   = {r, p[2*WIDTH-1]};
  assign r_nxt  = (r_sh >= {1'b0, m}) ? (r_sh - {1'b0, m}) : r_sh;
  assign op_res = r_nxt[WIDTH-1:0];

  assign mul_b = (state == MUL) ? b : acc;

  always_comb begin
    prod = '0;
    if (state == REDUCE_BASE) prod = {{WIDTH{1'b0}}, b};
    else                      prod = acc * mul_b;
  end

  // A MUL on a zero exponent bit still runs but its product is dropped.
  always_comb begin
    acc_upd = acc;
    if (op_last && ((state == SQR) || ((state == MUL) && ebit))) acc_upd = op_res;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (bus.ready_in) state_nxt = (bus.modulus_in == '0) ? DONE : REDUCE_BASE;
      REDUCE_BASE: if (op_last) state_nxt = SQR;
      SQR: begin
        if (op_last) begin
`ifdef MOD_EXP_EARLY_EXIT_EN
          if (ebit)             state_nxt = MUL;
          else if (idx == '0)   state_nxt = DONE;
          else                  state_nxt = SQR;
`else
          state_nxt = MUL;
`endif
        end
      end
      MUL:         if (op_last) state_nxt = (idx == '0) ? DONE : SQR;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt    <= '0;
      p      <= '0;
      r      <= '0;
      acc    <= '0;
      b      <= '0;
      m      <= '0;
      e      <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ready_in) begin
            b   <= bus.base_in;
            e   <= bus.exponent_in;
            m   <= bus.modulus_in;
            idx <= IDX_TOP;
            cnt <= '0;
            acc <= (bus.modulus_in == '0) ? '0 : WIDTH'(1);
            if (bus.modulus_in == '0) result <= '0;
          end
        end
        REDUCE_BASE, SQR, MUL: begin
          if (cnt == '0) begin
            p   <= prod;
            r   <= '0;
            cnt <= CW'(1);
          end else begin
            p   <= p << 1;
            r   <= op_res;
            cnt <= op_last ? '0 : cnt + 1'b1;
          end
          acc <= acc_upd;
          if (op_last && (state == REDUCE_BASE)) b <= op_res;
          if (op_last && (state != REDUCE_BASE) && (state_nxt == SQR)) idx <= idx - 1'b1;
          if (state_nxt == DONE) result <= acc_upd;
        end
        default: ;
      endcase
    end
  end

  assign bus.result_out = result;
  assign bus.busy_out   = in_op;
  assign bus.valid_out  = (state == DONE);
endmodule
